serial_adder: RTL

- Bit-serial adder: adds two WIDTH-bit operands one bit per clock through a single full-adder bit cell, with a registered carry.
- Sits around the team's FA cell. It feeds the cell operand LSBs plus the stored carry, and consumes the cell's S/Cout outputs.
- Trades WIDTH cycles of latency for one adder cell. Used where area matters more than throughput, e.g. the lab datapath accumulator.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/fa.sv | 20 ++
 rtl/serial_adder_bitcell.sv | 25 ++
 rtl/serial_adder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg : shared state encoding and sizing helpers for serial_adder
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter indexes bits 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa : one-bit full-adder cell
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder_bitcell.sv
// -----------------------------------------------------------------------------
// serial_adder_bitcell : combinational bit slice wrapping the fa cell
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module serial_adder_bitcell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  fa u_fa (
    .a  (a),
    .b  (b),
    .ci (cin),
    .s  (s),
    .co (cout)
  );

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder : bit-serial unsigned adder, one bit per clock through one cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg_a;
  logic [WIDTH-1:0] shreg_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             bit_s;
  logic             bit_co;
  logic             accept;
  logic             last;

  serial_adder_bitcell u_bitcell (
    .a    (shreg_a[0]),
    .b    (shreg_b[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_co)
  );

  assign last       = (cnt == LAST_BIT);
  assign result_nxt = {bit_s, result[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back start is accepted straight out of DONE.
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg_a <= '0;
      shreg_b <= '0;
      result  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg_a <= a;
        shreg_b <= b;
        carry   <= cin;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        shreg_a <= shreg_a >> 1;
        shreg_b <= shreg_b >> 1;
        result  <= result_nxt;
        carry   <= bit_co;
        cnt     <= cnt + 1'b1;
        if (last) begin
          sum  <= result_nxt;
          cout <= bit_co;
        end
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last edge the carry register holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && last) begin
      ovf <= carry ^ bit_co;
    end
  end
`endif

endmodule

`default_nettype wire
